mmu_sequencer: RTL

Sequences the 3x3 weight-stationary systolic MMU for one MATMUL.

---
 rtl/mmu_ctrl_pkg.sv | 27 ++
 rtl/mmu_valid_pipe.sv | 34 +++
 rtl/mmu_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mmu_ctrl_pkg.sv
// Shared state encoding, tag bundle and timing helpers
// for the 3x3 weight-stationary MMU sequencer.
package mmu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_W,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    function automatic int load_len(input int n, input int cap_lat);
        return 2 * (n - 1) + cap_lat + 1;
    endfunction

    function automatic int out_lat(input int n, input int c);
        return n + c;
    endfunction

endpackage

// File: rtl/mmu_valid_pipe.sv
// Delays each activation's {valid,last} tag to line up
// with the accumulator output of every column.
module mmu_valid_pipe
    import mmu_ctrl_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  tag_t         tag_in,
    output logic [N-1:0] acc_valid,
    output logic [N-1:0] acc_last
);

    tag_t sh [2*N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2 * N; i++) sh[i] <= '0;
        end else begin
            sh[0] <= tag_in;
            for (int i = 1; i < 2 * N; i++) sh[i] <= sh[i-1];
        end
    end

    // sh[0] is aligned with row_in, so tap k is k cycles later
    always_comb begin
        for (int c = 0; c < N; c++) begin
            acc_valid[c] = sh[out_lat(N, c)].valid;
            acc_last[c]  = sh[out_lat(N, c)].last;
        end
    end

endmodule

// File: rtl/mmu_sequencer.sv
// Sequences one MATMUL on the systolic MMU: weight fetch,
// staggered weight load, activation streaming and drain.
module mmu_sequencer
    import mmu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_SIZE = 3,
    parameter int CAP_LAT    = 0,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             keep_weights,
    input  logic                             use_signed_in,
    input  logic [CNT_W-1:0]                 num_vecs,
    output logic                             busy,
    output logic                             done,
    input  logic                             wt_valid,
    output logic                             wt_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] wt_data,
    input  logic                             act_valid,
    output logic                             act_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] act_data,
    output logic                             en_weight_pass,
    output logic [ARRAY_SIZE*ARRAY_SIZE-1:0] en_capture,
    output logic                             use_signed,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] row_in,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] col_in,
    output logic [ARRAY_SIZE-1:0]            acc_valid,
    output logic [ARRAY_SIZE-1:0]            acc_last
);

    localparam int N  = ARRAY_SIZE;
    localparam int DW = DATA_WIDTH;
    localparam int LL = load_len(N, CAP_LAT);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, nv_q;
    logic             w_loaded, wt_acc, act_acc;
    logic [N*DW-1:0]  wbuf [N];
    tag_t             tag_in;

    assign wt_acc  = wt_valid & wt_ready;
    assign act_acc = act_valid & act_ready;

    always_comb begin
        tag_in.valid = act_acc;
        tag_in.last  = act_acc && (cnt == nv_q - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (keep_weights && w_loaded)
                        state_n = (num_vecs == '0) ? DONE : STREAM;
                    else
                        state_n = FETCH_W;
                end
            end
            FETCH_W: begin
                if (wt_acc && cnt == CNT_W'(N - 1))
                    state_n = LOAD;
            end
            LOAD: begin
                if (cnt == CNT_W'(LL - 1))
                    state_n = (nv_q == '0) ? DONE : STREAM;
            end
            STREAM: begin
                if (act_acc && cnt == nv_q - CNT_W'(1))
                    state_n = DRAIN;
            end
            DRAIN: begin
                if (acc_last[N-1]) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != IDLE);
        done           = (state == DONE);
        wt_ready       = (state == FETCH_W);
        act_ready      = (state == STREAM);
        en_weight_pass = (state == LOAD);
        en_capture     = '0;
        // row r sees W[r] on its psum input 2r cycles into the load
        if (state == LOAD) begin
            for (int r = 0; r < N; r++) begin
                if (cnt == CNT_W'(2 * r + CAP_LAT))
                    en_capture[r*N +: N] = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            nv_q       <= '0;
            w_loaded   <= 1'b0;
            use_signed <= 1'b0;
            row_in     <= '0;
            col_in     <= '0;
            for (int i = 0; i < N; i++) wbuf[i] <= '0;
        end else begin
            if (state_n != state)
                cnt <= '0;
            else if (wt_acc || act_acc || state == LOAD)
                cnt <= cnt + CNT_W'(1);
            if (state == IDLE && start) begin
                nv_q       <= num_vecs;
                use_signed <= use_signed_in;
            end
            if (wt_acc) wbuf[cnt[IW-1:0]] <= wt_data;
            if (state == LOAD && state_n != LOAD) w_loaded <= 1'b1;
            row_in <= act_acc ? act_data : '0;
            // col_in runs one row ahead of the load counter
            if (wt_acc && state_n == LOAD)
                col_in <= wbuf[0];
            else if (state == LOAD && cnt < CNT_W'(N - 1))
                col_in <= wbuf[IW'(cnt + CNT_W'(1))];
            else
                col_in <= '0;
        end
    end

    mmu_valid_pipe #(
        .N(N)
    ) u_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .tag_in   (tag_in),
        .acc_valid(acc_valid),
        .acc_last (acc_last)
    );

endmodule
